// File: rtl/mem_slave_pkg.sv
// Shared types and constants for the mem_slave request/ack memory target.
// Optional wait-state support is enabled by defining MEM_SLAVE_WAIT_EN.
package mem_slave_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_ACK  = 2'd2,
      S_HOLD = 2'd3
   } state_e;

   localparam logic        CMD_READ  = 1'b0;
   localparam logic        CMD_WRITE = 1'b1;
   localparam logic [31:0] ERR_RDATA = 32'h0;

   // Any set bit above the word index puts the address outside local storage.
   function automatic logic addr_oor(input logic [31:0] a, input int unsigned dl2);
      return (a >> (dl2 + 2)) != 32'h0;
   endfunction

endpackage

// File: rtl/mem_slave_ram.sv
// Word storage for mem_slave: async-cleared array, one write port, one registered read port.
// Read data is captured only on a read strobe and otherwise holds; rclr forces a zero capture.
module mem_slave_ram
   import mem_slave_pkg::*;
#(
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  arst,
   input  logic                  i_we,
   input  logic [DEPTH_LOG2-1:0] i_waddr,
   input  logic [31:0]           i_wdata,
   input  logic                  i_re,
   input  logic                  i_rclr,
   input  logic [DEPTH_LOG2-1:0] i_raddr,
   output logic [31:0]           o_rdata
);

   localparam int DEPTH = 2 ** DEPTH_LOG2;

   logic [31:0] r_mem [DEPTH];
   logic [31:0] r_rdata;

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= 32'h0;
         end
         r_rdata <= 32'h0;
      end else begin
         if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
         end
         if (i_re) begin
            r_rdata <= i_rclr ? ERR_RDATA : r_mem[i_raddr];
         end
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_slave.sv
// Request/ack memory target with optional wait states (MEM_SLAVE_WAIT_EN) and out-of-range error.
// ack/err/rdata are registered on the edge entering ACK; the FSM parks in HOLD until req drops.
module mem_slave
   import mem_slave_pkg::*;
#(
   parameter int DEPTH_LOG2  = 4,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        arst,
   input  logic        req,
   input  logic        cmd,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        ack,
   output logic [31:0] rdata,
   output logic        err
);

   state_e                r_state;
   state_e                w_state_nxt;
   logic                  w_cmd;
   logic [31:0]           w_addr;
   logic [31:0]           w_wdata;
   logic                  w_oor;
   logic [DEPTH_LOG2-1:0] w_idx;
   logic                  w_go_ack;
   logic                  r_ack;
   logic                  r_err;

`ifdef MEM_SLAVE_WAIT_EN
   localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

   logic        r_cmd;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [3:0]  r_cnt;

   // A zero-wait hop out of IDLE must commit with the live inputs, everything later uses the latch.
   assign w_cmd   = (r_state == S_IDLE) ? cmd   : r_cmd;
   assign w_addr  = (r_state == S_IDLE) ? addr  : r_addr;
   assign w_wdata = (r_state == S_IDLE) ? wdata : r_wdata;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (req) w_state_nxt = (WAIT_LD != 4'd0) ? S_WAIT : S_ACK;
         S_WAIT:  begin
            if (!req)               w_state_nxt = S_IDLE;
            else if (r_cnt == 4'd1) w_state_nxt = S_ACK;
         end
         S_ACK:   w_state_nxt = S_HOLD;
         S_HOLD:  if (!req) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         r_cmd   <= CMD_READ;
         r_addr  <= 32'h0;
         r_wdata <= 32'h0;
         r_cnt   <= 4'd0;
      end else begin
         if (r_state == S_IDLE && req) begin
            r_cmd   <= cmd;
            r_addr  <= addr;
            r_wdata <= wdata;
            r_cnt   <= WAIT_LD;
         end else if (r_state == S_WAIT && req) begin
            r_cnt <= r_cnt - 4'd1;
         end else begin
            r_cnt <= 4'd0;
         end
      end
   end
`else
   assign w_cmd   = cmd;
   assign w_addr  = addr;
   assign w_wdata = wdata;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (req) w_state_nxt = S_ACK;
         S_ACK:   w_state_nxt = S_HOLD;
         S_HOLD:  if (!req) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end
`endif

   assign w_oor    = addr_oor(w_addr, DEPTH_LOG2);
   assign w_idx    = w_addr[DEPTH_LOG2+1:2];
   assign w_go_ack = (w_state_nxt == S_ACK);

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         r_state <= S_IDLE;
         r_ack   <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_ack   <= w_go_ack;
         r_err   <= w_go_ack && w_oor;
      end
   end

   mem_slave_ram #(
      .DEPTH_LOG2(DEPTH_LOG2)
   ) u_ram (
      .clk     (clk),
      .arst    (arst),
      .i_we    (w_go_ack && (w_cmd == CMD_WRITE) && !w_oor),
      .i_waddr (w_idx),
      .i_wdata (w_wdata),
      .i_re    (w_go_ack && (w_cmd == CMD_READ)),
      .i_rclr  (w_oor),
      .i_raddr (w_idx),
      .o_rdata (rdata)
   );

   assign ack = r_ack;
   assign err = r_err;

endmodule

// File: tb/tb_mem_slave.sv
// Directed bench for mem_slave: scoreboard of expected err/rdata per transaction, checked at ack.
// Ack latency, single-pulse ack, abort, reset and out-of-range behaviour are checked against a model.
module tb_mem_slave;
   import mem_slave_pkg::*;

   localparam int DL2 = 4;
   localparam int WC  = 2;
`ifdef MEM_SLAVE_WAIT_EN
   localparam int LAT = WC;
`else
   localparam int LAT = 0;
`endif

   logic        clk = 1'b0;
   logic        arst;
   logic        req;
   logic        cmd;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        ack;
   logic [31:0] rdata;
   logic        err;

   mem_slave #(
      .DEPTH_LOG2 (DL2),
      .WAIT_CYCLES(WC)
   ) dut (
      .clk  (clk),
      .arst (arst),
      .req  (req),
      .cmd  (cmd),
      .addr (addr),
      .wdata(wdata),
      .ack  (ack),
      .rdata(rdata),
      .err  (err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        err;
      logic [31:0] rdata;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] m_mem [16];
   logic [31:0] m_last;
   int          n_pass  = 0;
   int          n_total = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m_mem[i] = 32'h0;
      m_last = 32'h0;
      sb.delete();
   endtask

   // One full handshake; inputs are scrambled right after the request edge.
   task automatic txn(input string tag, input logic c, input logic [31:0] a,
                      input logic [31:0] d, input int hold);
      exp_t e;
      logic oor;
      int   idx;
      oor = (a[31:DL2+2] != '0);
      idx = int'(a[DL2+1:2]);
      if (c == CMD_READ) m_last = oor ? ERR_RDATA : m_mem[idx];
      else if (!oor)     m_mem[idx] = d;
      e.err   = oor;
      e.rdata = m_last;
      sb.push_back(e);

      @(negedge clk);
      req = 1'b1; cmd = c; addr = a; wdata = d;
      @(posedge clk); #2;
      cmd = ~c; addr = ~a; wdata = ~d;
      for (int n = 0; n < LAT; n++) begin
         chk({tag, " early_ack"}, {31'b0, ack}, 32'h0);
         @(posedge clk); #1;
      end
      chk({tag, " ack"}, {31'b0, ack}, 32'h1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk({tag, " err"}, {31'b0, err}, {31'b0, e.err});
         chk({tag, " rdata"}, rdata, e.rdata);
      end
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         chk({tag, " held_ack"}, {31'b0, ack}, 32'h0);
      end
      @(negedge clk);
      req = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk({tag, " idle_ack"}, {31'b0, ack}, 32'h0);
      chk({tag, " idle_err"}, {31'b0, err}, 32'h0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      arst = 1'b1; req = 1'b0; cmd = CMD_READ; addr = 32'h0; wdata = 32'h0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst ack", {31'b0, ack}, 32'h0);
      chk("rst err", {31'b0, err}, 32'h0);
      chk("rst rdata", rdata, 32'h0);
      @(negedge clk);
      arst = 1'b0;
      repeat (2) @(posedge clk);

      txn("wr8",    CMD_WRITE, 32'h0000_0008, 32'hA5A5_0001, 0);
      txn("rd8",    CMD_READ,  32'h0000_0008, 32'h0,         0);
      txn("rdB",    CMD_READ,  32'h0000_000B, 32'h0,         0);
      txn("wr3C",   CMD_WRITE, 32'h0000_003C, 32'h5A5A_C3C3, 0);
      txn("rd3C",   CMD_READ,  32'h0000_003C, 32'h0,         0);
      txn("wr40",   CMD_WRITE, 32'h0000_0040, 32'h0000_1234, 0);
      txn("rd0",    CMD_READ,  32'h0000_0000, 32'h0,         0);
      txn("rd3C_2", CMD_READ,  32'h0000_003C, 32'h0,         0);
      txn("rd80",   CMD_READ,  32'h8000_0000, 32'h0,         0);

`ifdef MEM_SLAVE_WAIT_EN
      @(negedge clk);
      req = 1'b1; cmd = CMD_WRITE; addr = 32'h4; wdata = 32'hDEAD_BEEF;
      @(posedge clk);
      @(negedge clk);
      req = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         chk("abort ack", {31'b0, ack}, 32'h0);
      end
      txn("rd4_abort", CMD_READ, 32'h0000_0004, 32'h0, 0);
`endif

      txn("wr10_hold", CMD_WRITE, 32'h0000_0010, 32'h0000_BEEF, 3);
      txn("rd10_hold", CMD_READ,  32'h0000_0010, 32'h0,         3);

      @(negedge clk);
      req = 1'b1; cmd = CMD_WRITE; addr = 32'hC; wdata = 32'hFFFF_FFFF;
      @(posedge clk); #2;
      arst = 1'b1;
      #1;
      chk("midrst ack", {31'b0, ack}, 32'h0);
      chk("midrst rdata", rdata, 32'h0);
      @(negedge clk);
      arst = 1'b0; req = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("postrst ack", {31'b0, ack}, 32'h0);
      txn("rdC_rst", CMD_READ, 32'h0000_000C, 32'h0, 0);
      txn("rd8_rst", CMD_READ, 32'h0000_0008, 32'h0, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
